// File: rtl/ov7670_cap_pkg.sv
// Shared types and QQVGA geometry for the OV7670 capture path.
package ov7670_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CLOSE   = 2'd3
    } cap_state_t;

    localparam int IMG_W        = 160;
    localparam int IMG_H        = 120;
    localparam int QQVGA_PIXELS = IMG_W * IMG_H;

endpackage

// File: rtl/ov7670_sync_edge.sv
// One-register edge detector: registers a level and flags its rising/falling transitions.
module ov7670_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = ~sig_q & sig_i;
    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/ov7670_frame_ctrl.sv
// Frame capture sequencer: gates decimator writes to whole frames, checks pixel count,
// and ping-pongs the two frame-buffer banks between writer and display reader.
module ov7670_frame_ctrl
    import ov7670_cap_pkg::*;
#(
    parameter int FRAME_PIXELS = QQVGA_PIXELS,
    parameter int ADDR_WIDTH   = 15,
    parameter int CNT_W        = 15,
    parameter int DROP_W       = 8
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [11:0]           din,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic                  rd_frame_start,
    output logic [ADDR_WIDTH:0]   wr_addr,
    output logic [11:0]           wr_data,
    output logic                  wr_en,
    output logic                  rd_bank,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic [1:0]            state_dbg
);

    localparam logic [CNT_W-1:0]  PIX_FULL = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  PIX_MAX  = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    cap_state_t          state_q, state_d;
    logic                rd_bank_q, rd_bank_d;
    logic                wr_bank_q, wr_bank_d;
    logic                pending_q, pending_d;
    logic                stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0] wr_addr_q;
    logic [11:0]         wr_data_q;
    logic                vsync_rise, vsync_fall;
    logic                swap;

    ov7670_sync_edge u_vsync_edge (
        .clk_i  (pclk),
        .rst_i  (rst),
        .sig_i  (vsync),
        .rise_o (vsync_rise),
        .fall_o (vsync_fall)
    );

    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        wr_bank_d   = wr_bank_q;
        pending_d   = pending_q;
        stop_pend_d = stop_pend_q;
        pix_cnt_d   = pix_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        swap        = rd_frame_start & pending_q & (state_q != ST_CAPTURE);
        wr_en_d     = we_in & (state_q == ST_CAPTURE) & (pix_cnt_q < PIX_FULL);

        if (swap) begin
            rd_bank_d = ~rd_bank_q;
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (vsync_fall) begin
                    state_d   = ST_CAPTURE;
                    pix_cnt_d = '0;
                    // Write bank follows the reader's bank after any swap in this same cycle.
                    wr_bank_d = ~rd_bank_d;
                    if (pending_q && !swap) begin
                        pending_d = 1'b0;
                        if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (we_in && (pix_cnt_q != PIX_MAX)) pix_cnt_d = pix_cnt_q + 1'b1;
                if (stop) stop_pend_d = 1'b1;
                if (vsync_rise) state_d = ST_CLOSE;
            end
            ST_CLOSE: begin
                if (pix_cnt_q == PIX_FULL) pending_d = 1'b1;
                state_d     = (continuous && !stop_pend_q) ? ST_ARM : ST_IDLE;
                stop_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_bank_q   <= 1'b0;
            wr_bank_q   <= 1'b1;
            pending_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            pix_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {1'b1, {ADDR_WIDTH{1'b0}}};
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            pending_q   <= pending_d;
            stop_pend_q <= stop_pend_d;
            pix_cnt_q   <= pix_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= {wr_bank_q, addr_in};
            wr_data_q   <= din;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign rd_bank    = rd_bank_q;
    assign frame_done = (state_q == ST_CLOSE) && (pix_cnt_q == PIX_FULL);
    assign frame_err  = (state_q == ST_CLOSE) && (pix_cnt_q != PIX_FULL);
    assign busy       = (state_q != ST_IDLE);
    assign drop_cnt   = drop_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/ov7670_frame_ctrl.md
# ov7670_frame_ctrl

Frame-level capture sequencer and ping-pong bank controller that sits between the OV7670 decimator and the dual-bank QQVGA frame buffer. It arms capture on command and gates the decimator's write strobe to whole frames only. It validates each frame's pixel count and hands completed frames to the display reader by bank swap, counting frames dropped because the reader did not take them in time.

## Interface
- FRAME_PIXELS, 19200: accepted pixels per valid frame (160x120).
- ADDR_WIDTH, 15: decimator address width; buffer address is ADDR_WIDTH+1 (bank bit on top).
- CNT_W, 15: pixel counter width; saturates at all-ones.
- DROP_W, 8: dropped-frame counter width; saturates at all-ones.
- pclk  in  1  camera pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- vsync  in  1  camera VSYNC (high between frames).
- we_in  in  1  decimator write strobe, one cycle per kept pixel.
- addr_in  in  ADDR_WIDTH  decimator compact address.
- din  in  12  RGB444 pixel.
- start  in  1  pulse: arm capture.
- stop  in  1  pulse: stop after the current frame.
- continuous  in  1  level: 1 = re-arm after each frame; 0 = single shot.
- rd_frame_start  in  1  pulse from display vblank, already in pclk domain.
- wr_addr  out  ADDR_WIDTH+1  {wr_bank, addr_in}, registered.
- wr_data  out  12  din, registered.
- wr_en  out  1  gated write strobe, registered.
- rd_bank  out  1  bank the display reads.
- frame_done  out  1  one-cycle pulse: valid frame published.
- frame_err  out  1  one-cycle pulse: frame closed with pixel count != FRAME_PIXELS.
- busy  out  1  state != IDLE.
- drop_cnt  out  DROP_W  frames overwritten before the reader took them.

## Operation
- Edges: vsync_d registered; vsync_fall = vsync_d & ~vsync (frame start); vsync_rise = ~vsync_d & vsync (frame end).
- States: IDLE, ARM, CAPTURE, CLOSE.
  - IDLE: start -> ARM. If start and stop arrive together, stop wins and the block stays in IDLE.
  - ARM: vsync_fall -> CAPTURE. stop -> IDLE.
  - CAPTURE: vsync_rise -> CLOSE. stop sets stop_pend; capture continues.
  - CLOSE, one cycle: -> ARM if continuous & ~stop_pend, else -> IDLE. stop_pend is cleared on leaving CLOSE.
- start outside IDLE is ignored.
- On ARM->CAPTURE:
  - Clear pix_cnt.
  - If pending = 1, clear it and increment drop_cnt, saturating.
  - Latch wr_bank = ~rd_bank, using the rd_bank value after any same-cycle swap.
- In CAPTURE, each we_in increments pix_cnt, saturating. Write is passed only while pix_cnt < FRAME_PIXELS; excess pixels are suppressed so the neighbouring bank is never written.
- In CLOSE:
  - pix_cnt == FRAME_PIXELS: frame_done, pending <= 1.
  - Otherwise: frame_err, and pending is unchanged.
- Reader swap: rd_frame_start & pending & state != CAPTURE -> rd_bank <= ~rd_bank, pending <= 0. In every other case rd_frame_start is ignored.
- Reset values: state IDLE, rd_bank 0, wr_bank 1, pending 0, stop_pend 0, pix_cnt 0, drop_cnt 0. All outputs are 0 except wr_addr[ADDR_WIDTH] = 1.
- Reset mid-frame aborts immediately; any partial bank contents are discarded.

## Timing
- wr_en, wr_addr and wr_data lag we_in/addr_in/din by 1 cycle.
- wr_en = we_in & (state == CAPTURE) & (pix_cnt < FRAME_PIXELS), evaluated in the we_in cycle.
- frame_done and frame_err assert in the CLOSE cycle, which is 1 cycle after the vsync_rise sample.
- rd_bank changes the cycle after a qualifying rd_frame_start.
- we_in in the same cycle as vsync_rise is still counted. we_in in the vsync_fall cycle is dropped.
- drop_cnt updates 1 cycle after the ARM->CAPTURE transition.

## Structure
- Package ov7670_cap_pkg holds:
  - state encoding (IDLE=0, ARM=1, CAPTURE=2, CLOSE=3);
  - QQVGA constants IMG_W=160, IMG_H=120, FRAME_PIXELS default.
- Sub-module ov7670_sync_edge provides the vsync register plus rise/fall outputs, with asynchronous reset. Everything else is flat in one module.

## Test plan
- Single shot, continuous=0, start, then one frame of exactly 19200 we_in:
  - 19200 wr_en with wr_addr[15]=1;
  - frame_done once; state returns to IDLE;
  - rd_frame_start -> rd_bank=1.
- Short frame of 19199 pixels, then long frame of 19250 pixels:
  - frame_err each time, no frame_done, pending stays 0;
  - on the long frame exactly 19200 wr_en.
- Continuous mode, three good frames, no rd_frame_start: drop_cnt=2 and rd_bank=0. Then one rd_frame_start in ARM -> rd_bank=1.
- rd_frame_start coincident with the ARM->CAPTURE transition while pending=1:
  - swap occurs, drop_cnt unchanged;
  - new frame writes bank 0.
- stop mid-CAPTURE finishes the frame (frame_done) and ends in IDLE. start+stop together in IDLE leaves busy=0.
- rst asserted mid-frame (asynchronous, between clock edges): all outputs at reset values immediately. Re-arm then yields a clean 19200-pixel frame.
